m_stage: RTL and testbench

//  Merge stage of the JOIN pipeline; the opposite end of the branch stage.
//  Two upstream Send/Ack channels (a, b) are merged into one downstream Send/Ack channel.
//  The 38-bit packet is arbitrated, registered once, and forwarded unchanged.
//  A SRC flag reports which input the packet came from.
//  The stage sits where the a/b branches of the ring rejoin, ahead of the next stage.

---
 rtl/m_stage.sv | 104 ++++++++++
 tb/tb_m_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_stage.sv
`default_nettype none
// ============================================================================
// Module      : m_stage
// Description : JOIN merge stage. Arbitrates two 4-phase Send/Ack inputs onto
//               one registered 4-phase Send/Ack output and tags the source.
// Revision    : 1.0 - initial release
// ============================================================================
module m_stage #(
    parameter int WIDTH = 38,
    parameter bit RR    = 1'b1
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             Send_in_a,
    input  logic             Send_in_b,
    input  logic [WIDTH-1:0] PACKET_IN_a,
    input  logic [WIDTH-1:0] PACKET_IN_b,
    output logic             Ack_out_a,
    output logic             Ack_out_b,
    output logic             Send_out,
    input  logic             Ack_in,
    output logic [WIDTH-1:0] PACKET_OUT,
    output logic             SRC
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_last_b;
    logic             r_ack_a;
    logic             r_ack_b;
    logic             r_send;
    logic             r_out_done;
    logic             r_src;
    logic [WIDTH-1:0] r_packet;

    logic             w_any_req;
    logic             w_grant_b;
    logic             w_send_g;
    logic             w_in_done;

    // On a tie, b wins only in round-robin mode when a held the last grant.
    always_comb begin
        w_any_req = Send_in_a | Send_in_b;
        w_grant_b = Send_in_b & (~Send_in_a | (RR & ~r_last_b));
        w_send_g  = r_src ? Send_in_b : Send_in_a;
        w_in_done = ~(r_ack_a | r_ack_b);
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            r_state    <= S_IDLE;
            r_last_b   <= 1'b1;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_send     <= 1'b0;
            r_out_done <= 1'b0;
            r_src      <= 1'b0;
            r_packet   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_packet   <= w_grant_b ? PACKET_IN_b : PACKET_IN_a;
                        r_src      <= w_grant_b;
                        r_last_b   <= w_grant_b;
                        r_ack_a    <= ~w_grant_b;
                        r_ack_b    <= w_grant_b;
                        r_send     <= 1'b1;
                        r_out_done <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!w_send_g) begin
                        r_ack_a <= 1'b0;
                        r_ack_b <= 1'b0;
                    end
                    // Output side: Ack_in high retires Send_out, Ack_in low completes.
                    if (r_send && Ack_in) begin
                        r_send <= 1'b0;
                    end else if (!r_send && !Ack_in) begin
                        r_out_done <= 1'b1;
                    end
                    if (w_in_done && r_out_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Ack_out_a  = r_ack_a;
    assign Ack_out_b  = r_ack_b;
    assign Send_out   = r_send;
    assign PACKET_OUT = r_packet;
    assign SRC        = r_src;

endmodule
`default_nettype wire

// File: tb/tb_m_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_stage
// Description : Self-checking bench for m_stage; one round-robin and one
//               fixed-priority instance against a transaction-phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_stage;

    logic              clk;
    logic              mr;
    logic [1:0]        sa, sb, ai;
    logic [37:0]       pa [2];
    logic [37:0]       pb [2];
    logic              aoa0, aob0, so0, src0, aoa1, aob1, so1, src1;
    logic [37:0]       po0, po1;
    wire  [1:0]        aoa = {aoa1, aoa0};
    wire  [1:0]        aob = {aob1, aob0};
    wire  [1:0]        so  = {so1, so0};
    wire  [1:0]        src = {src1, src0};

    int                checks;
    int                errors;

    // Reference model: per instance, a transfer is busy, has a grant, an
    // input-side pending flag and an output phase (0 send,1 wait low,2 done).
    bit   [1:0]        m_busy, m_g, m_last, m_inp, m_cap;
    int                m_oph [2];
    logic [37:0]       m_pkt [2];
    bit   [1:0]        m_src;
    bit                obs_q0 [$];
    bit                obs_q1 [$];

    bit                auto_en, want_a, want_b;
    int unsigned       prob;
    logic [37:0]       cap [2];

    m_stage #(.WIDTH(38), .RR(1'b1)) u_rr (
        .CP(clk), .MR(mr), .Send_in_a(sa[0]), .Send_in_b(sb[0]),
        .PACKET_IN_a(pa[0]), .PACKET_IN_b(pb[0]), .Ack_out_a(aoa0), .Ack_out_b(aob0),
        .Send_out(so0), .Ack_in(ai[0]), .PACKET_OUT(po0), .SRC(src0)
    );

    m_stage #(.WIDTH(38), .RR(1'b0)) u_fp (
        .CP(clk), .MR(mr), .Send_in_a(sa[1]), .Send_in_b(sb[1]),
        .PACKET_IN_a(pa[1]), .PACKET_IN_b(pb[1]), .Ack_out_a(aoa1), .Ack_out_b(aob1),
        .Send_out(so1), .Ack_in(ai[1]), .PACKET_OUT(po1), .SRC(src1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] obs_po(input int d);
        return (d == 0) ? po0 : po1;
    endfunction

    function automatic logic e_aoa(input int d);
        return m_busy[d] && m_inp[d] && !m_g[d];
    endfunction

    function automatic logic e_aob(input int d);
        return m_busy[d] && m_inp[d] && m_g[d];
    endfunction

    function automatic logic e_so(input int d);
        return m_busy[d] && (m_oph[d] == 0);
    endfunction

    function automatic logic [37:0] rnd_pkt();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    function automatic bit coin();
        return $urandom_range(99) < prob;
    endfunction

    task automatic chk(input string tag, input int d, input logic [37:0] obs, input logic [37:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_last[d] = 1'b1;
            m_inp[d]  = 1'b0;
            m_oph[d]  = 2;
            m_pkt[d]  = '0;
            m_src[d]  = 1'b0;
            m_cap[d]  = 1'b0;
        end
    endtask

    task automatic model_step(input int d);
        bit a, b, k, g, s, done;
        a = sa[d];
        b = sb[d];
        k = ai[d];
        m_cap[d] = 1'b0;
        if (!mr) return;
        if (!m_busy[d]) begin
            if (a || b) begin
                // instance 0 is round-robin, instance 1 fixed priority to a
                if (a && b) g = (d == 0) ? !m_last[d] : 1'b0;
                else        g = b;
                m_busy[d] = 1'b1;
                m_g[d]    = g;
                m_last[d] = g;
                m_inp[d]  = 1'b1;
                m_oph[d]  = 0;
                m_pkt[d]  = g ? pb[d] : pa[d];
                m_src[d]  = g;
                m_cap[d]  = 1'b1;
            end
        end else begin
            done = !m_inp[d] && (m_oph[d] == 2);
            s    = m_g[d] ? b : a;
            if (!s) m_inp[d] = 1'b0;
            if (m_oph[d] == 0 && k)       m_oph[d] = 1;
            else if (m_oph[d] == 1 && !k) m_oph[d] = 2;
            if (done) m_busy[d] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_ack_a"}, d, aoa[d], e_aoa(d));
            chk({tag, "_ack_b"}, d, aob[d], e_aob(d));
            chk({tag, "_send"},  d, so[d], e_so(d));
            chk({tag, "_src"},   d, src[d], m_src[d]);
            chk({tag, "_pkt"},   d, obs_po(d), m_pkt[d]);
            chk({tag, "_excl"},  d, aoa[d] & aob[d], 1'b0);
        end
    endtask

    task automatic agents();
        for (int d = 0; d < 2; d++) begin
            if (sa[d] && e_aoa(d)) begin
                if (coin()) sa[d] = 1'b0;
            end else if (!sa[d] && !e_aoa(d) && want_a) begin
                if (coin()) begin sa[d] = 1'b1; pa[d] = rnd_pkt(); end
            end
            if (sb[d] && e_aob(d)) begin
                if (coin()) sb[d] = 1'b0;
            end else if (!sb[d] && !e_aob(d) && want_b) begin
                if (coin()) begin sb[d] = 1'b1; pb[d] = rnd_pkt(); end
            end
            if (e_so(d) && !ai[d]) begin
                if (coin()) ai[d] = 1'b1;
            end else if (!e_so(d) && ai[d]) begin
                if (coin()) ai[d] = 1'b0;
            end
        end
    endtask

    // One clock: model follows the sampled inputs, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        check_all("cyc");
        if (m_cap[0]) obs_q0.push_back(src[0]);
        if (m_cap[1]) obs_q1.push_back(src[1]);
        @(negedge clk);
        if (auto_en) agents();
    endtask

    task automatic drain(input int n);
        auto_en = 1'b1; want_a = 1'b0; want_b = 1'b0; prob = 100;
        repeat (n) tick();
        auto_en = 1'b0;
    endtask

    initial begin
        logic v;
        checks = 0; errors = 0;
        mr = 1'b0; sa = '0; sb = '0; ai = '0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
        auto_en = 1'b0; want_a = 1'b0; want_b = 1'b0; prob = 100;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        for (int d = 0; d < 2; d++) chk("reset_pkt_zero", d, obs_po(d), 38'h0);
        mr = 1'b1;

        // Single transfer from a
        for (int d = 0; d < 2; d++) begin pa[d] = 38'h2A_5555_0001; sa[d] = 1'b1; end
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("single_ack_a", d, aoa[d], 1'b1);
            chk("single_send", d, so[d], 1'b1);
            chk("single_pkt", d, obs_po(d), 38'h2A_5555_0001);
            chk("single_src", d, src[d], 1'b0);
        end
        sa = '0;
        tick(); tick();
        ai = 2'b11;
        tick();
        for (int d = 0; d < 2; d++) chk("single_send_drop", d, so[d], 1'b0);
        ai = '0;
        tick(); tick();

        // Ack_in in IDLE is ignored
        ai = 2'b11;
        tick(); tick();
        for (int d = 0; d < 2; d++) chk("idle_ack_ignored", d, so[d] | aoa[d] | aob[d], 1'b0);
        ai = '0;
        tick();

        // Slow downstream with a pending a request
        for (int d = 0; d < 2; d++) begin pb[d] = rnd_pkt(); cap[d] = pb[d]; end
        sb = 2'b11;
        tick();
        sb = '0; sa = 2'b11;
        for (int d = 0; d < 2; d++) pa[d] = rnd_pkt();
        repeat (20) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk("slow_dn_send", d, so[d], 1'b1);
                chk("slow_dn_pkt", d, obs_po(d), cap[d]);
                chk("slow_dn_no_ack_a", d, aoa[d], 1'b0);
            end
        end
        ai = 2'b11; tick();
        ai = '0;    tick(); tick();
        for (int d = 0; d < 2; d++) chk("slow_dn_idle", d, aoa[d], 1'b0);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("slow_dn_next_grant", d, aoa[d], 1'b1);
            chk("slow_dn_next_src", d, src[d], 1'b0);
        end
        drain(16);

        // Asynchronous reset in the middle of a transfer
        sa = 2'b11;
        for (int d = 0; d < 2; d++) begin pa[d] = rnd_pkt(); cap[d] = pa[d]; end
        tick();
        for (int d = 0; d < 2; d++) chk("pre_reset_send", d, so[d], 1'b1);
        #2;
        mr = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        for (int d = 0; d < 2; d++) chk("async_reset_outs", d, {so[d], aoa[d], obs_po(d)}, 38'h0);
        @(negedge clk);
        mr = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("post_reset_grant", d, aoa[d], 1'b1);
            chk("post_reset_pkt", d, obs_po(d), cap[d]);
        end
        drain(16);

        // Slow upstream release on b with a pending a request
        for (int d = 0; d < 2; d++) pb[d] = rnd_pkt();
        sb = 2'b11;
        tick();
        ai = 2'b11; tick();
        ai = '0; sa = 2'b11;
        for (int d = 0; d < 2; d++) pa[d] = rnd_pkt();
        tick();
        repeat (8) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk("slow_up_ack_b", d, aob[d], 1'b1);
                chk("slow_up_ack_a", d, aoa[d], 1'b0);
            end
        end
        sb = '0;
        tick();
        for (int d = 0; d < 2; d++) chk("slow_up_release", d, {aob[d], aoa[d]}, 2'b00);
        tick();
        for (int d = 0; d < 2; d++) chk("slow_up_idle_edge", d, aoa[d], 1'b0);
        tick();
        for (int d = 0; d < 2; d++) chk("slow_up_regrant", d, aoa[d], 1'b1);
        drain(16);

        // Continuous tie: RR alternates a,b,...; fixed priority always a
        mr = 1'b0; model_reset(); @(negedge clk); mr = 1'b1;
        obs_q0.delete(); obs_q1.delete();
        for (int d = 0; d < 2; d++) begin pa[d] = rnd_pkt(); pb[d] = rnd_pkt(); end
        sa = 2'b11; sb = 2'b11;
        auto_en = 1'b1; want_a = 1'b1; want_b = 1'b1; prob = 100;
        repeat (40) tick();
        for (int i = 0; i < 4; i++) begin
            v = (i < obs_q0.size()) ? obs_q0[i] : 1'bx;
            chk("tie_rr_order", 0, v, i % 2);
            v = (i < obs_q1.size()) ? obs_q1[i] : 1'bx;
            chk("tie_fixed_a", 1, v, 1'b0);
        end
        obs_q1.delete();
        want_a = 1'b0;
        repeat (40) tick();
        v = (obs_q1.size() != 0) ? obs_q1[obs_q1.size() - 1] : 1'bx;
        chk("fixed_b_after_a_idle", 1, v, 1'b1);
        drain(20);

        // Randomised traffic
        auto_en = 1'b1; want_a = 1'b1; want_b = 1'b1; prob = 50;
        repeat (2000) tick();
        drain(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
